// File: rtl/itch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : itch_pkg
// Description : Shared constants for the ITCH message dispatcher: message type
//               bytes, expected message lengths (type byte included), one-hot
//               decoder indices and the assembly buffer size.
// Revision    : 1.0 - initial release
// ============================================================================
package itch_pkg;

    // Assembly buffer depth in bytes; the byte counter only needs enough
    // bits to address this buffer.
    localparam int MAX_MSG_BYTES = 64;
    localparam int CNT_BITS      = $clog2(MAX_MSG_BYTES);

    typedef logic [CNT_BITS-1:0] len_t;

    // Message type bytes (ASCII)
    localparam logic [7:0] TYPE_ADD_ORDER      = 8'h41; // 'A'
    localparam logic [7:0] TYPE_ORDER_CANCEL   = 8'h58; // 'X'
    localparam logic [7:0] TYPE_ORDER_DELETE   = 8'h44; // 'D'
    localparam logic [7:0] TYPE_ORDER_REPLACE  = 8'h55; // 'U'
    localparam logic [7:0] TYPE_ORDER_EXECUTED = 8'h45; // 'E'

    // Expected total lengths, including the type byte
    localparam len_t LEN_ADD_ORDER      = len_t'(36);
    localparam len_t LEN_ORDER_CANCEL   = len_t'(23);
    localparam len_t LEN_ORDER_DELETE   = len_t'(19);
    localparam len_t LEN_ORDER_REPLACE  = len_t'(35);
    localparam len_t LEN_ORDER_EXECUTED = len_t'(31);

    // Bit positions in the one-hot dispatch vector
    localparam int IDX_ADD_ORDER      = 0;
    localparam int IDX_ORDER_CANCEL   = 1;
    localparam int IDX_ORDER_DELETE   = 2;
    localparam int IDX_ORDER_REPLACE  = 3;
    localparam int IDX_ORDER_EXECUTED = 4;

endpackage : itch_pkg
`default_nettype wire

// File: rtl/itch_type_lookup.sv
`default_nettype none
// ============================================================================
// Module      : itch_type_lookup
// Description : Combinational decode of an ITCH type byte into a known flag,
//               the expected message length and the one-hot decoder select.
// Ports       : type_byte  in   first byte of a message
//               known      out  type byte is one of the dispatched types
//               exp_len    out  expected length in bytes (0 when unknown)
//               onehot     out  decoder select (0 when unknown)
// Revision    : 1.0 - initial release
// ============================================================================
module itch_type_lookup
    import itch_pkg::*;
#(
    parameter int NUM_DEC = 5
) (
    input  logic [7:0]         type_byte,
    output logic               known,
    output logic [5:0]         exp_len,
    output logic [NUM_DEC-1:0] onehot
);

    always_comb begin
        known   = 1'b1;
        exp_len = '0;
        onehot  = '0;
        case (type_byte)
            TYPE_ADD_ORDER: begin
                exp_len                   = LEN_ADD_ORDER;
                onehot[IDX_ADD_ORDER]     = 1'b1;
            end
            TYPE_ORDER_CANCEL: begin
                exp_len                   = LEN_ORDER_CANCEL;
                onehot[IDX_ORDER_CANCEL]  = 1'b1;
            end
            TYPE_ORDER_DELETE: begin
                exp_len                   = LEN_ORDER_DELETE;
                onehot[IDX_ORDER_DELETE]  = 1'b1;
            end
            TYPE_ORDER_REPLACE: begin
                exp_len                   = LEN_ORDER_REPLACE;
                onehot[IDX_ORDER_REPLACE] = 1'b1;
            end
            TYPE_ORDER_EXECUTED: begin
                exp_len                     = LEN_ORDER_EXECUTED;
                onehot[IDX_ORDER_EXECUTED]  = 1'b1;
            end
            default: begin
                known = 1'b0;
            end
        endcase
    end

endmodule : itch_type_lookup
`default_nettype wire

// File: rtl/itch_msg_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : itch_msg_dispatcher
// Description : Assembles an ITCH byte stream MSB-first into a 512-bit payload,
//               checks the length against the per-type expected length and
//               hands the message to one decoder with a one-hot valid/ready
//               handshake. Malformed messages are dropped and counted.
// Ports       : clk, rst_n       clock, synchronous active-low reset
//               in_valid/in_ready/in_byte/in_last   byte stream input
//               payload          assembled message, byte i at [511-8i -: 8]
//               dec_valid        one-hot dispatch (A,X,D,U,E = bit0..bit4)
//               out_ready        decoder bank accepts the dispatch
//               length_error     one-cycle pulse on a length mismatch
//               unknown_type     one-cycle pulse on an unrecognised type
//               msg_count        messages dispatched (wraps)
//               drop_count       messages dropped (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module itch_msg_dispatcher
    import itch_pkg::*;
#(
    parameter int NUM_DEC = 5,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [7:0]         in_byte,
    input  logic               in_last,
    output logic               in_ready,
    output logic [511:0]       payload,
    output logic [NUM_DEC-1:0] dec_valid,
    input  logic               out_ready,
    output logic               length_error,
    output logic               unknown_type,
    output logic [CNT_W-1:0]   msg_count,
    output logic [CNT_W-1:0]   drop_count
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_COLLECT  = 2'd1;
    localparam logic [1:0] ST_DISPATCH = 2'd2;
    localparam logic [1:0] ST_DROP     = 2'd3;

    logic [1:0]         r_state;
    logic [511:0]       r_payload;
    logic [NUM_DEC-1:0] r_dec_valid;
    logic [NUM_DEC-1:0] r_onehot;
    len_t               r_cnt;
    len_t               r_exp_len;
    logic               r_length_error;
    logic               r_unknown_type;
    logic [CNT_W-1:0]   r_msg_count;
    logic [CNT_W-1:0]   r_drop_count;

    logic               w_known;
    logic [5:0]         w_exp_len;
    logic [NUM_DEC-1:0] w_onehot;
    logic               w_accept;
    len_t               w_cnt_next;
    logic               w_at_len;
    logic [8:0]         w_wr_msb;

    itch_type_lookup #(
        .NUM_DEC   (NUM_DEC)
    ) u_type_lookup (
        .type_byte (in_byte),
        .known     (w_known),
        .exp_len   (w_exp_len),
        .onehot    (w_onehot)
    );

    always_comb begin
        in_ready   = (r_state != ST_DISPATCH);
        w_accept   = in_valid && in_ready;
        w_cnt_next = r_cnt + len_t'(1);
        // True when the byte being accepted is the last one the type allows.
        w_at_len   = (w_cnt_next == r_exp_len);
        // MSB of byte slot r_cnt: 511 - 8*r_cnt
        w_wr_msb   = 9'd511 - {r_cnt, 3'b000};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_payload      <= '0;
            r_dec_valid    <= '0;
            r_onehot       <= '0;
            r_cnt          <= '0;
            r_exp_len      <= '0;
            r_length_error <= 1'b0;
            r_unknown_type <= 1'b0;
            r_msg_count    <= '0;
            r_drop_count   <= '0;
        end else begin
            // Error flags are single-cycle pulses.
            r_length_error <= 1'b0;
            r_unknown_type <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_payload <= {in_byte, 504'd0};
                        r_cnt     <= len_t'(1);
                        if (!w_known) begin
                            r_unknown_type <= 1'b1;
                            r_drop_count   <= r_drop_count + CNT_W'(1);
                            r_state        <= in_last ? ST_IDLE : ST_DROP;
                        end else if (in_last) begin
                            r_length_error <= 1'b1;
                            r_drop_count   <= r_drop_count + CNT_W'(1);
                            r_state        <= ST_IDLE;
                        end else begin
                            r_exp_len <= w_exp_len;
                            r_onehot  <= w_onehot;
                            r_state   <= ST_COLLECT;
                        end
                    end
                end

                ST_COLLECT: begin
                    if (w_accept) begin
                        r_payload[w_wr_msb -: 8] <= in_byte;
                        r_cnt                    <= w_cnt_next;
                        if (in_last && w_at_len) begin
                            r_dec_valid <= r_onehot;
                            r_state     <= ST_DISPATCH;
                        end else if (in_last || w_at_len) begin
                            // Short (last too early) or long (no last at the
                            // expected length); a long message drains in DROP.
                            r_length_error <= 1'b1;
                            r_drop_count   <= r_drop_count + CNT_W'(1);
                            r_state        <= in_last ? ST_IDLE : ST_DROP;
                        end
                    end
                end

                ST_DISPATCH: begin
                    if (out_ready) begin
                        r_dec_valid <= '0;
                        r_msg_count <= r_msg_count + CNT_W'(1);
                        r_state     <= ST_IDLE;
                    end
                end

                ST_DROP: begin
                    if (w_accept && in_last) begin
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        payload      = r_payload;
        dec_valid    = r_dec_valid;
        length_error = r_length_error;
        unknown_type = r_unknown_type;
        msg_count    = r_msg_count;
        drop_count   = r_drop_count;
    end

endmodule : itch_msg_dispatcher
`default_nettype wire
